// File: rtl/somador_fsm.sv
// somador_fsm: Moore FSM that sums memory words 0..LAST_SRC and writes the total to DEST_ADDR
module somador_fsm #(
    parameter int LAST_SRC  = 30,
    parameter int DEST_ADDR = 31
) (
    input  logic       clk,
    input  logic       reset,
    output logic [4:0] address,
    output logic       rden,
    output logic       wren,
    output logic       load,
    output logic       transf,
    output logic       clear,
    output logic       ready
);
    localparam logic [4:0] LAST = LAST_SRC[4:0];
    localparam logic [4:0] DEST = DEST_ADDR[4:0];

    typedef enum logic [2:0] {
        CLEAR  = 3'd0,
        READ   = 3'd1,
        LOAD   = 3'd2,
        TRANSF = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;

    // state and source-address counter registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next-state and Moore output decode from state and counter only
    always_comb begin
        state_d = CLEAR;
        cnt_d   = cnt_q;
        address = 5'd0;
        rden    = 1'b0;
        wren    = 1'b0;
        load    = 1'b0;
        transf  = 1'b0;
        clear   = 1'b0;
        ready   = 1'b0;
        case (state_q)
            CLEAR: begin
                clear   = 1'b1;
                cnt_d   = 5'd0;
                state_d = READ;
            end
            READ: begin
                rden    = 1'b1;
                address = cnt_q;
                state_d = LOAD;
            end
            LOAD: begin
                rden    = 1'b1;
                load    = 1'b1;
                address = cnt_q;
                state_d = (cnt_q == LAST) ? TRANSF : READ;
                cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + 5'd1;
            end
            TRANSF: begin
                transf  = 1'b1;
                address = DEST;
                state_d = WRITE;
            end
            WRITE: begin
                wren    = 1'b1;
                address = DEST;
                state_d = DONE;
            end
            DONE: begin
                ready   = 1'b1;
                address = DEST;
                state_d = DONE;
            end
            default: state_d = CLEAR;
        endcase
    end
endmodule

// File: tb/tb_somador_fsm.sv
// tb_somador_fsm: directed scoreboard bench for somador_fsm with a memory/accumulator model
module tb_somador_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] address;
    logic       rden, wren, load, transf, clear, ready;

    int total = 0;
    int bad = 0;

    logic [10:0] sb[$];
    logic [15:0] mem[32];
    logic [15:0] rdata, acc, wdata;

    somador_fsm dut (
        .clk(clk), .reset(reset), .address(address), .rden(rden), .wren(wren),
        .load(load), .transf(transf), .clear(clear), .ready(ready)
    );

    always #5 clk = ~clk;

    // external memory with 1-cycle read latency plus accumulator driven by the FSM strobes
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) mem[k] <= 16'(k + 1);
            acc   <= 16'd0;
            rdata <= 16'd0;
            wdata <= 16'd0;
        end else begin
            if (rden) rdata <= mem[address];
            if (clear) acc <= 16'd0;
            else if (load) acc <= acc + rdata;
            if (transf) wdata <= acc;
            if (wren) mem[address] <= wdata;
        end
    end

    // per-cycle exclusivity of the strobes and rden only in READ/LOAD
    always @(negedge clk) begin
        total++;
        assert ($onehot0({clear, load, transf, wren, ready}) && !(rden && (clear || transf || wren || ready)))
        else begin
            bad++;
            $error("FAIL excl obs=%b", {rden, clear, load, transf, wren, ready});
        end
    end

    // expected {address, rden, wren, load, transf, clear, ready} n edges after reset release
    function automatic logic [10:0] exp_vec(int n);
        logic [4:0] a;
        a = 5'((n - 1) / 2);
        if (n == 0) return {5'd0, 6'b000010};
        if (n <= 62) return (n % 2 == 1) ? {a, 6'b100000} : {a, 6'b101000};
        if (n == 63) return {5'd31, 6'b000100};
        if (n == 64) return {5'd31, 6'b010000};
        return {5'd31, 6'b000001};
    endfunction

    task automatic check(input string tag);
        logic [10:0] obs, exp;
        obs = {address, rden, wren, load, transf, clear, ready};
        exp = sb.pop_front();
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic run_edges(input int count, input string tag);
        for (int n = 1; n <= count; n++) begin
            sb.push_back(exp_vec(n));
            @(posedge clk);
            #1;
            check($sformatf("%s_e%0d", tag, n));
        end
    endtask

    task automatic async_reset(input string tag);
        #3 reset = 1'b1;
        #1;
        sb.push_back(exp_vec(0));
        check({tag, "_now"});
        sb.push_back(exp_vec(0));
        @(posedge clk);
        #1;
        check({tag, "_held"});
        reset = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        total++;
        assert (mem[31] === 16'd496)
        else begin
            bad++;
            $error("FAIL %s obs=%0d exp=496", tag, mem[31]);
        end
    endtask

    initial begin
        #1;
        sb.push_back(exp_vec(0));
        check("rst_async");
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exp_vec(0));
            @(posedge clk);
            #1;
            check($sformatf("rst_hold%0d", i));
        end
        reset = 1'b0;
        run_edges(75, "run1");
        check_mem("mem31_run1");
        async_reset("rst_done");
        run_edges(20, "part");
        async_reset("rst_mid");
        run_edges(75, "run2");
        check_mem("mem31_run2");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/somador_fsm.md
SOMADOR_FSM -- requirements
Module: somador_fsm

Interface
REQ-001 Parameter LAST_SRC, default 30: highest source address summed; legal range 0..30.
REQ-002 Parameter DEST_ADDR, default 31: address the sum is written to.
REQ-003 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port address, output, 5: memory address for current read or write.
REQ-006 Port rden, output, 1: memory read enable.
REQ-007 Port wren, output, 1: memory write enable.
REQ-008 Port load, output, 1: accumulator adds the current memory read data this cycle.
REQ-009 Port transf, output, 1: accumulator value is copied to the memory write-data register.
REQ-010 Port clear, output, 1: accumulator is zeroed.
REQ-011 Port ready, output, 1: sum has been written; operation complete.

Function
REQ-012 The block SHALL be a Moore FSM; every output is decoded only from the state register and a 5-bit address counter, with no combinational path from any input.
REQ-013 States SHALL be CLEAR, READ, LOAD, TRANSF, WRITE, DONE; any unused encoding SHALL go to CLEAR on the next edge.
REQ-014 CLEAR: clear=1, address=0, all other outputs 0; next state READ.
REQ-015 READ: rden=1, address=counter; next state LOAD (one-cycle memory latency).
REQ-016 LOAD: rden=1, load=1, address=counter; if counter==LAST_SRC, next state TRANSF; otherwise counter increments by 1 and next state READ.
REQ-017 TRANSF: transf=1, address=DEST_ADDR; next state WRITE.
REQ-018 WRITE: wren=1, address=DEST_ADDR; next state DONE.
REQ-019 DONE: ready=1, address=DEST_ADDR, all enables 0; the FSM SHALL hold in DONE until reset.
REQ-020 At most one of clear, load, transf, wren and ready SHALL be high in any cycle; rden is high only in READ and LOAD.
REQ-021 The counter SHALL never exceed LAST_SRC and SHALL never wrap.
REQ-022 With defaults, the FSM SHALL reach DONE on the 65th rising edge after reset deasserts (1 + 2*(LAST_SRC+1) + 2).

Reset
REQ-023 While reset=1, state SHALL be CLEAR and counter SHALL be 0, giving outputs clear=1, address=0, all others 0; this SHALL take effect immediately, without waiting for a clock edge.
REQ-024 Reset asserted mid-operation, including in DONE, SHALL abort the operation and restart from CLEAR on deassertion.
REQ-025 Reset deasserting in the same cycle as a clock edge SHALL leave the FSM in CLEAR for that edge; the first transition happens on the following edge.

Verification
REQ-026 Hold reset=1 for 2 cycles -> clear=1, address=0, rden=wren=load=transf=ready=0 throughout.
REQ-027 Release reset -> edge 1: READ with address=0 and rden=1; edge 2: LOAD with address=0 and load=1; edge 3: READ with address=1.
REQ-028 Run to completion -> edge 62: LOAD with address=30; edge 63: transf=1 with address=31; edge 64: wren=1 with address=31; edge 65: ready=1, which then stays high for 10 more cycles.
REQ-029 Pair with a memory holding word k = k+1 and a 1-cycle-latency accumulator -> after ready, memory[31] = 496.
REQ-030 Assert reset asynchronously between edges at edge 20 -> outputs switch at once to clear=1, address=0; on release the full 65-edge sequence repeats exactly.
REQ-031 Every cycle, check the output exclusivity rule in REQ-020 with an assertion.
